stack_game_ctrl: RTL
====================

// Module: stack_game_ctrl
// PURPOSE
//  Top-level sequencer for the stacker game. It paces the 8-bit block shifter with a
//  level-dependent shift pulse and captures the block position on a stop press.
//  It checks overlap with the row below, then writes the surviving row and shrinks the block.
//  It declares win or loss and sits between the debounced buttons, the block shifter and the row display.
// PARAMETERS
//  ROWS         8            rows to stack before a win (2..8)
//  BASE_DIV     24'd5000000  clk cycles per shift at level 0
//  DIV_STEP     24'd500000   divisor decrement per level
//  MIN_DIV      24'd1000000  floor on divisor
//  INIT_PATTERN 8'b11100000  block loaded on game start
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  startBtn     in   1  debounced start/restart level
//  stopBtn      in   1  debounced stop level
//  blockLoc     in   8  current block position from shifter
//  adjClkPulse  out  1  one-cycle shift enable to shifter
//  loadBlock    out  1  one-cycle load strobe to shifter
//  loadPattern  out  8  pattern loaded when loadBlock=1
//  rowWe        out  1  one-cycle row write strobe to display
//  rowIdx       out  3  row being played / written
//  rowMask      out  8  row data written when rowWe=1
//  rowClr       out  1  one-cycle clear-all-rows strobe
//  level        out  3  current level (= rows completed, saturates at 7)
//  gameOver     out  1  high in LOSE
//  gameWin      out  1  high in WIN
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, prevMask 8'hFF; button history regs reset to 1.
//  A button held through reset therefore yields no edge.
//  Edges: rise = btn & ~btnQ, registered; a press acts 1 cycle after it is sampled.
//  Divisor: div = max(BASE_DIV - level*DIV_STEP, MIN_DIV); compute unsigned with underflow guard.
//  Tick counter: width 24, counts 0..div-1 in RUN only, cleared on leaving RUN.
//  States:
//   IDLE  : outputs idle; startRise -> START.
//   START : rowClr=1, loadBlock=1, loadPattern=INIT_PATTERN, rowIdx=0, level=0, prevMask=FF.
//           Next: RUN.
//   RUN   : adjClkPulse=1 for one cycle when counter==div-1. stopRise -> LATCH.
//           stopRise and tick in the same cycle: stop wins, adjClkPulse suppressed.
//           startRise ignored.
//   LATCH : m = blockLoc & prevMask. If m==0 -> LOSE, with no row write.
//           Otherwise rowWe=1, rowMask=m, prevMask<=m; if rowIdx==ROWS-1 -> WIN, else -> NEXT.
//   NEXT  : rowIdx++, level++ (saturating at 7), loadBlock=1, loadPattern=m (narrowed block).
//           Next: RUN.
//   WIN/LOSE: gameWin/gameOver held high; no shifts; startRise -> START.
//           START clears the flag in the same cycle it pulses rowClr.
//  Strobes (adjClkPulse, loadBlock, rowWe, rowClr) never exceed one cycle and are mutually exclusive.
//  Exception: loadBlock and rowClr coincide in START.
//  blockLoc is sampled only in LATCH. A non-one-hot or zero blockLoc is legal; zero produces a loss.
//  rst asserted mid-game returns everything to reset values on the next edge; no row write completes.
// STRUCTURE
//  stack_game_defs.vh: state encodings (IDLE..LOSE, 3 bits) and the default INIT_PATTERN.
//  Sub-module btn_rise (registered rising-edge detector, reset-to-1 history), instantiated twice.
//  The FSM, tick counter and divisor logic live in this module.
// TESTING (sim params: ROWS=3, BASE_DIV=4, DIV_STEP=1, MIN_DIV=2)
//  1 Reset then startBtn pulse -> rowClr & loadBlock together one cycle, loadPattern=E0.
//    Then adjClkPulse every 4 clk.
//  2 Stop with blockLoc=E0 on row 0 -> rowWe, rowMask=E0, rowIdx=0.
//    Then NEXT: loadPattern=E0, level=1, pulses every 3 clk.
//  3 Row 1 blockLoc=70 with prevMask E0 -> rowMask=60, next loadPattern=60.
//    Level 2 pulse period 2 (clamped at MIN_DIV thereafter).
//  4 Row 1 blockLoc=1C with prevMask E0 -> no rowWe, gameOver=1.
//    Then startBtn -> gameOver=0 and rowClr.
//  5 Three successful stops -> third rowWe at rowIdx=2, then gameWin=1, adjClkPulse stays 0.
//  6 stopRise coincident with tick -> no adjClkPulse. stopBtn held through rst -> no latch.
//    rst during RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stack_game_ctrl_pkg.sv
// Shared types and helpers for the stacker game sequencer.
package stack_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_LATCH = 3'd3,
        ST_NEXT  = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOSE  = 3'd6
    } state_t;

    localparam logic [7:0] INIT_PATTERN_DEF = 8'b11100000;
    localparam int         CNT_W            = 24;

    // Shift divisor for a level: base minus level*step, floored at min_div.
    // The product is formed wide so a large level*step cannot wrap past zero.
    function automatic logic [CNT_W-1:0] calc_div(
        input logic [CNT_W-1:0] base_div,
        input logic [CNT_W-1:0] div_step,
        input logic [CNT_W-1:0] min_div,
        input logic [2:0]       lvl
    );
        logic [CNT_W+2:0] dec;
        logic [CNT_W-1:0] rem;
        dec = (CNT_W+3)'(div_step) * (CNT_W+3)'(lvl);
        if (dec >= (CNT_W+3)'(base_div)) begin
            return min_div;
        end
        rem = base_div - dec[CNT_W-1:0];
        if (rem < min_div) begin
            return min_div;
        end
        return rem;
    endfunction

endpackage

// File: rtl/stack_game_ctrl_btn_rise.sv
// Registered rising-edge detector for a debounced button level.
// History resets to 1 so a button held through reset produces no edge.
module stack_game_ctrl_btn_rise (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    // Track previous level and register the rising edge one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b1;
            rise  <= 1'b0;
        end else begin
            btn_q <= btn;
            rise  <= btn & ~btn_q;
        end
    end

endmodule

// File: rtl/stack_game_ctrl.sv
// Stacker game sequencer: paces the block shifter, latches the block on a
// stop press, checks overlap with the row below, writes rows, declares win/loss.
//
//  state | meaning
//  IDLE  | waiting for the first start press after reset
//  START | clear the display and load the initial block
//  RUN   | block shifting; stop press moves to LATCH
//  LATCH | overlap block with previous row; write row or lose
//  NEXT  | advance row/level and load the narrowed block
//  WIN   | all rows stacked; start press restarts
//  LOSE  | no overlap; start press restarts
module stack_game_ctrl
    import stack_game_ctrl_pkg::*;
#(
    parameter int          ROWS         = 8,
    parameter logic [23:0] BASE_DIV     = 24'd5000000,
    parameter logic [23:0] DIV_STEP     = 24'd500000,
    parameter logic [23:0] MIN_DIV      = 24'd1000000,
    parameter logic [7:0]  INIT_PATTERN = INIT_PATTERN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startBtn,
    input  logic       stopBtn,
    input  logic [7:0] blockLoc,
    output logic       adjClkPulse,
    output logic       loadBlock,
    output logic [7:0] loadPattern,
    output logic       rowWe,
    output logic [2:0] rowIdx,
    output logic [7:0] rowMask,
    output logic       rowClr,
    output logic [2:0] level,
    output logic       gameOver,
    output logic       gameWin
);

    state_t             state_q;
    state_t             state_d;
    logic               start_rise;
    logic               stop_rise;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   div_cur;
    logic               tick;
    logic [2:0]         row_idx;
    logic [2:0]         level_q;
    logic [7:0]         prev_mask;
    logic [7:0]         latch_mask;
    logic               last_row;
    logic               enter_start;

    stack_game_ctrl_btn_rise u_start_rise (
        .clk  (clk),
        .rst  (rst),
        .btn  (startBtn),
        .rise (start_rise)
    );

    stack_game_ctrl_btn_rise u_stop_rise (
        .clk  (clk),
        .rst  (rst),
        .btn  (stopBtn),
        .rise (stop_rise)
    );

    assign div_cur     = calc_div(BASE_DIV, DIV_STEP, MIN_DIV, level_q);
    assign tick        = (cnt_q >= (div_cur - 24'd1));
    assign latch_mask  = blockLoc & prev_mask;
    assign last_row    = (row_idx == 3'(ROWS - 1));
    assign enter_start = (state_d == ST_START) && (state_q != ST_START);

    assign rowIdx   = row_idx;
    assign level    = level_q;
    assign gameOver = (state_q == ST_LOSE);
    assign gameWin  = (state_q == ST_WIN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d     = state_q;
        adjClkPulse = 1'b0;
        loadBlock   = 1'b0;
        loadPattern = 8'h00;
        rowWe       = 1'b0;
        rowMask     = 8'h00;
        rowClr      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_START;
            end
            ST_START: begin
                rowClr      = 1'b1;
                loadBlock   = 1'b1;
                loadPattern = INIT_PATTERN;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // A stop press in the tick cycle wins; the block must not move.
                if (stop_rise) begin
                    state_d = ST_LATCH;
                end else if (tick) begin
                    adjClkPulse = 1'b1;
                end
            end
            ST_LATCH: begin
                if (latch_mask == 8'h00) begin
                    state_d = ST_LOSE;
                end else begin
                    rowWe   = 1'b1;
                    rowMask = latch_mask;
                    state_d = last_row ? ST_WIN : ST_NEXT;
                end
            end
            ST_NEXT: begin
                loadBlock   = 1'b1;
                loadPattern = prev_mask;
                state_d     = ST_RUN;
            end
            ST_WIN, ST_LOSE: begin
                if (start_rise) state_d = ST_START;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shift timer: free-running modulo div while in RUN, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q != ST_RUN) || (state_d != ST_RUN)) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 24'd1;
        end
    end

    // Game progress: row index, level and the surviving mask of the row below.
    // Cleared on the way into START so START already presents row 0 / level 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_idx   <= 3'd0;
            level_q   <= 3'd0;
            prev_mask <= 8'hFF;
        end else if (enter_start) begin
            row_idx   <= 3'd0;
            level_q   <= 3'd0;
            prev_mask <= 8'hFF;
        end else if ((state_q == ST_LATCH) && (latch_mask != 8'h00)) begin
            prev_mask <= latch_mask;
        end else if (state_q == ST_NEXT) begin
            row_idx <= row_idx + 3'd1;
            if (level_q != 3'd7) begin
                level_q <= level_q + 3'd1;
            end
        end
    end

endmodule
